uart_tx_fifo_controller: RTL and testbench

UART_TX_FIFO_CONTROLLER -- requirements
Module: uart_tx_fifo_controller

---
 rtl/uart_tx_fifo_controller.sv | 127 ++++++++++++
 tb/tb_uart_tx_fifo_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_controller.sv
// UART transmitter (8N1, 16 baud_ticks per bit) fed by a circular byte FIFO; a load into an idle empty FIFO starts the frame on the next edge.
// No backpressure: a load while Full is dropped and latches Overrun; Enable gates only the start of new frames.
module uart_tx_fifo_controller #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Load_data,
  input  logic [7:0] TX_data,
  input  logic       baud_tick,
  output logic       Full,
  output logic       Empty,
  output logic       Busy,
  output logic       Overrun,
  output logic       UART_TX_O
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    tick_count, tick_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          tx, tx_nxt;
  logic          wr_en, pop, bit_end;

  assign Full      = (count == CW'(FIFO_DEPTH));
  assign Empty     = (count == '0);
  assign Busy      = (state != IDLE);
  assign UART_TX_O = tx;
  assign wr_en     = Load_data && !Full;
  assign bit_end   = baud_tick && (tick_count == 4'd15);

  // Storage is not reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr] <= TX_data;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      Overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as Enable=0 must still leave Overrun set.
      if (Load_data && Full) Overrun <= 1'b1;
      else if (!Enable)      Overrun <= 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      tick_count <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
    end else begin
      state      <= state_nxt;
      tick_count <= tick_nxt;
      bit_idx    <= bit_nxt;
      shreg      <= shreg_nxt;
      tx         <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_count;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    tx_nxt    = tx;
    pop       = 1'b0;
    if (state != IDLE && baud_tick) tick_nxt = tick_count + 4'd1;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (Enable && !Empty) begin
          pop       = 1'b1;
          shreg_nxt = mem[rd_ptr];
          tick_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          tx_nxt    = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            shreg_nxt = {1'b0, shreg[7:1]};
            tx_nxt    = shreg[1];
            bit_nxt   = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_controller.sv
// Bench: byte queue model fed at load time, serial-line monitor decodes frames and checks flags every cycle.
module tb_uart_tx_fifo_controller;
  localparam int DEPTH = 4;

  logic       Clk = 1'b0;
  logic       Reset, Enable, Load_data, baud_tick;
  logic [7:0] TX_data;
  logic       Full, Empty, Busy, Overrun, UART_TX_O;

  uart_tx_fifo_controller #(.FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Load_data(Load_data),
    .TX_data(TX_data), .baud_tick(baud_tick), .Full(Full), .Empty(Empty),
    .Busy(Busy), .Overrun(Overrun), .UART_TX_O(UART_TX_O)
  );

  always #5 Clk = ~Clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  bit         drop_pending = 0;
  bit         exp_ovr = 0;
  int         tick_mode = 0;
  int         bcnt = 0;

  bit         in_frame = 0;
  int         bitn = 0;
  int         ticks = 0;
  logic       level = 1'b1;
  logic [7:0] rx_byte = '0;
  logic [7:0] exp_byte = '0;
  bit         idle_prev = 1;
  int         sz_prev = 0;
  bit         started;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // baud_tick: every 4th cycle, or random single-cycle pulses
  initial baud_tick = 1'b0;
  always @(posedge Clk) begin
    #2;
    if (tick_mode == 0) begin
      bcnt = (bcnt + 1) % 4;
      baud_tick = (bcnt == 0);
    end else begin
      baud_tick = !baud_tick && ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor: samples 1 time unit after each edge, inputs still show what the edge sampled
  always begin
    @(posedge Clk);
    #1;
    if (Reset) begin
      in_frame  = 0;
      exp_ovr   = 0;
      drop_pending = 0;
      sz_prev   = 0;
      idle_prev = 1;
    end else begin
      started = 0;
      if (in_frame) begin
        if (baud_tick) ticks++;
        if (ticks == 16) begin
          ticks = 0;
          bitn++;
          if (bitn == 10) begin
            in_frame = 0;
            level = 1'b1;
            check("frame_byte", rx_byte, exp_byte);
          end else if (bitn == 9) begin
            level = 1'b1;
          end else begin
            level = UART_TX_O;
            rx_byte[bitn-1] = UART_TX_O;
          end
        end
        check("line_level", UART_TX_O, level);
      end else if (UART_TX_O == 1'b0) begin
        started  = 1;
        in_frame = 1;
        bitn     = 0;
        ticks    = 0;
        level    = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame: start bit with no queued byte at %0t", $time);
        end else begin
          exp_byte = exp_q.pop_front();
        end
      end
      check("start_timing", started, idle_prev && Enable && (sz_prev > 0));
      if (drop_pending) exp_ovr = 1;
      else if (!Enable) exp_ovr = 0;
      drop_pending = 0;
      check("busy", Busy, in_frame);
      check("empty", Empty, exp_q.size() == 0);
      check("full", Full, exp_q.size() == DEPTH);
      check("overrun", Overrun, exp_ovr);
      sz_prev   = exp_q.size();
      idle_prev = !in_frame;
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic load(input logic [7:0] d);
    Load_data = 1'b1;
    TX_data   = d;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else drop_pending = 1;
    cyc();
    Load_data = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((exp_q.size() != 0 || in_frame) && k < limit) begin
      cyc();
      k++;
    end
    check("drain_done", exp_q.size() + int'(in_frame), 0);
    idle(3);
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b0; Load_data = 1'b0; TX_data = '0;
    #3;
    check("rst_tx", UART_TX_O, 1);
    check("rst_empty", Empty, 1);
    check("rst_full", Full, 0);
    check("rst_busy", Busy, 0);
    check("rst_overrun", Overrun, 0);
    cyc(); cyc();
    Reset = 1'b0;
    cyc();

    // single frame 0xA5, start bit on the edge after the load edge
    Enable = 1'b1;
    load(8'hA5);
    @(posedge Clk); #1;
    check("latency_start", UART_TX_O, 0);
    #1;
    drain(2000);

    // fill with Enable low, overflow, clear, then send in order
    Enable = 1'b0;
    load(8'h01); load(8'h02); load(8'h03); load(8'h04);
    check("full_after_4", Full, 1);
    load(8'hFF);
    check("overrun_set", Overrun, 1);
    cyc();
    check("overrun_cleared", Overrun, 0);
    Enable = 1'b1;
    drain(4000);
    check("empty_after_4", Empty, 1);

    // back-to-back frames
    load(8'h5A); load(8'hC3);
    drain(3000);

    // Enable dropped during START: frame completes, second byte stays queued
    load(8'h55); load(8'h66);
    Enable = 1'b0;
    begin
      int k = 0;
      while (in_frame && k < 2000) begin cyc(); k++; end
    end
    idle(20);
    check("held_empty", Empty, 0);
    check("held_count", exp_q.size(), 1);
    Enable = 1'b1;
    drain(2000);

    // full FIFO, load coincides with IDLE pop
    Enable = 1'b0;
    load(8'h10); load(8'h20); load(8'h30); load(8'h40);
    Enable = 1'b1;
    load(8'h99);
    check("coincide_overrun", Overrun, 1);
    check("coincide_full", Full, 0);
    drain(4000);
    Enable = 1'b0; cyc(); Enable = 1'b1;

    // reset during data bit 3 of 0x3C with two more bytes queued
    load(8'h3C); load(8'h11); load(8'h22);
    begin
      int k = 0;
      while (!(in_frame && bitn == 4 && ticks == 5) && k < 2000) begin cyc(); k++; end
    end
    check("reach_bit3", in_frame && bitn == 4, 1);
    Reset = 1'b1;
    #1;
    check("arst_tx", UART_TX_O, 1);
    check("arst_empty", Empty, 1);
    check("arst_busy", Busy, 0);
    check("arst_full", Full, 0);
    exp_q.delete();
    #1;
    cyc();
    Reset = 1'b0;
    idle(800);

    // randomized traffic with random tick spacing
    tick_mode = 1;
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 3) load(8'($urandom));
      else if (r == 3) begin Enable = ~Enable; cyc(); end
      else cyc();
    end
    Enable = 1'b1;
    drain(30000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
